// File: rtl/psum_acc_pkg.sv
// ---------------------------------------------------------------------------
// psum_acc_pkg
// Shared definitions for the partial-sum accumulator:
//   - beat field layout of the mac array -> psum accumulator stream
//   - accumulator width ACC_W
//   - FSM state encoding
//   - beat_sum(): folds the three signed branch fields of a beat into one
//     32-bit two's complement sum (wraps on overflow)
// ---------------------------------------------------------------------------
package psum_acc_pkg;

   localparam int ACC_W  = 32;
   localparam int BEAT_W = 64;

   // Beat field layout: [63:56] identity s8, [55:32] 1x1 psum s24, [31:0] 3x3 psum s32
   localparam int ID_LSB = 56;
   localparam int ID_W   = 8;
   localparam int S1_LSB = 32;
   localparam int S1_W   = 24;
   localparam int S3_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   function automatic logic signed [ACC_W-1:0] beat_sum(input logic [BEAT_W-1:0] beat);
      logic signed [ACC_W-1:0] s3;
      logic signed [ACC_W-1:0] s1;
      logic signed [ACC_W-1:0] id;
      s3 = beat[S3_W-1:0];
      s1 = {{(ACC_W-S1_W){beat[S1_LSB+S1_W-1]}}, beat[S1_LSB +: S1_W]};
      id = {{(ACC_W-ID_W){beat[ID_LSB+ID_W-1]}}, beat[ID_LSB +: ID_W]};
      return s3 + s1 + id;
   endfunction

endpackage

// File: rtl/psum_ram.sv
// ---------------------------------------------------------------------------
// psum_ram
// Simple dual-port partial-sum RAM, DEPTH x ACC_W.
// One write port, one read port; synchronous read with 1-cycle latency.
// The read register only updates when re_i is high, so a consumer that
// stalls keeps seeing the word it asked for. Read-during-write to the same
// address returns the old word; the caller forwards around that case.
//
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write index
//   wdata_i  in   write data
//   re_i     in   read enable
//   raddr_i  in   read index
//   rdata_o  out  read data, valid the cycle after re_i
// ---------------------------------------------------------------------------
module psum_ram
   import psum_acc_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [ACC_W-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [ACC_W-1:0]  rdata_o
);

   logic [ACC_W-1:0] mem_q [DEPTH];
   logic [ACC_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/psum_acc.sv
// ---------------------------------------------------------------------------
// psum_acc
// Receiving end of the mac array -> psum accumulator stream. Each accepted
// beat is folded into one signed sum and accumulated per pixel across all
// input-channel passes in psum_ram. On the last pass the finished pixel is
// sent to the output-map writer instead of being written back.
//
// Optional feature macro: PSUM_ACC_RELU_EN
//   defined   -> finished pixels are clamped at zero before the output register
//   undefined -> raw signed 32-bit sum is output
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   conv_start                  one-cycle start pulse (ignored outside IDLE)
//   in_ch                       passes per output channel (0 treated as 1)
//   map_size                    beats per pass
//   acc_ch_cnt                  current pass index
//   acc_done                    one-cycle pulse once all passes drained
//   mac_array2psum_acc_*        input beat stream (addr/data/vld/rdy)
//   psum_acc2omap_*             finished pixel stream (addr/data/vld/rdy)
// ---------------------------------------------------------------------------
module psum_acc
   import psum_acc_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               conv_start,
   input  logic [7:0]         in_ch,
   input  logic [15:0]        map_size,
   output logic [7:0]         acc_ch_cnt,
   output logic               acc_done,
   input  logic [31:0]        mac_array2psum_acc_addr,
   input  logic [BEAT_W-1:0]  mac_array2psum_acc_data,
   input  logic               mac_array2psum_acc_vld,
   output logic               mac_array2psum_acc_rdy,
   output logic [31:0]        psum_acc2omap_addr,
   output logic [ACC_W-1:0]   psum_acc2omap_data,
   output logic               psum_acc2omap_vld,
   input  logic               psum_acc2omap_rdy
);

`ifdef PSUM_ACC_RELU_EN
   function automatic logic signed [ACC_W-1:0] clamp_neg(input logic signed [ACC_W-1:0] x);
      return x[ACC_W-1] ? '0 : x;
   endfunction
`endif

   // Control state
   state_e      state_q, state_d;
   logic [7:0]  in_ch_q, in_ch_d;
   logic [15:0] map_q, map_d;
   logic [15:0] pix_q, pix_d;
   logic [7:0]  ch_q, ch_d;

   logic accept;
   logic stall;
   logic rdy;
   logic pipe_empty;

   // Stage 1 registers
   logic                     vld_p1_q;
   logic signed [ACC_W-1:0]  sum_p1_q;
   logic [31:0]              addr_p1_q;
   logic                     first_p1_q;
   logic                     last_p1_q;
   logic                     fwd_p1_q;
   logic signed [ACC_W-1:0]  fwd_data_p1_q;

   // Output register
   logic                     out_vld_q;
   logic [31:0]              out_addr_q;
   logic [ACC_W-1:0]         out_data_q;

   logic [ADDR_W-1:0]        rd_idx_p0;
   logic                     fwd_p0;
   logic [ACC_W-1:0]         ram_rdata;
   logic signed [ACC_W-1:0]  base_p1;
   logic signed [ACC_W-1:0]  acc_p1;
   logic signed [ACC_W-1:0]  final_p1;
   logic                     wr_en_p1;
   logic                     load_out_p1;

   assign stall      = out_vld_q && !psum_acc2omap_rdy;
   assign accept     = mac_array2psum_acc_vld && rdy;
   assign pipe_empty = !vld_p1_q && !out_vld_q;

   // ---- FSM: state and control registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         in_ch_q <= '0;
         map_q   <= '0;
         pix_q   <= '0;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         in_ch_q <= in_ch_d;
         map_q   <= map_d;
         pix_q   <= pix_d;
         ch_q    <= ch_d;
      end
   end

   // ---- FSM: next state and counters ----
   always_comb begin
      state_d = state_q;
      in_ch_d = in_ch_q;
      map_d   = map_q;
      pix_d   = pix_q;
      ch_d    = ch_q;
      unique case (state_q)
         ST_IDLE: begin
            if (conv_start) begin
               in_ch_d = (in_ch == 8'd0) ? 8'd1 : in_ch;
               map_d   = map_size;
               pix_d   = '0;
               ch_d    = '0;
               state_d = (map_size == 16'd0) ? ST_DRAIN : ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (pix_q == map_q - 16'd1) begin
                  pix_d = '0;
                  ch_d  = ch_q + 8'd1;
                  if (ch_q == in_ch_q - 8'd1) begin
                     state_d = ST_DRAIN;
                  end
               end else begin
                  pix_d = pix_q + 16'd1;
               end
            end
         end
         ST_DRAIN: begin
            if (pipe_empty) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      rdy      = 1'b0;
      acc_done = 1'b0;
      unique case (state_q)
         ST_RUN:   rdy      = !stall;
         ST_DRAIN: acc_done = pipe_empty;
         default:  ;
      endcase
   end

   assign mac_array2psum_acc_rdy = rdy;
   assign acc_ch_cnt             = ch_q;

   // ---- Stage 0: accept, RAM read issue, forward detect ----
   // A stage-1 write landing on the index being read this cycle is not yet
   // visible through the RAM read port, so its value is captured here and
   // substituted for ram_rdata one cycle later (needed for map_size==1).
   assign rd_idx_p0 = mac_array2psum_acc_addr[ADDR_W-1:0];
   assign fwd_p0    = wr_en_p1 && (addr_p1_q[ADDR_W-1:0] == rd_idx_p0);

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
      end else if (!stall) begin
         vld_p1_q <= accept;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         sum_p1_q      <= beat_sum(mac_array2psum_acc_data);
         addr_p1_q     <= mac_array2psum_acc_addr;
         first_p1_q    <= (ch_q == 8'd0);
         last_p1_q     <= (ch_q == in_ch_q - 8'd1);
         fwd_p1_q      <= fwd_p0;
         fwd_data_p1_q <= acc_p1;
      end
   end

   psum_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en_p1),
      .waddr_i (addr_p1_q[ADDR_W-1:0]),
      .wdata_i (acc_p1),
      .re_i    (accept),
      .raddr_i (rd_idx_p0),
      .rdata_o (ram_rdata)
   );

   // ---- Stage 1: accumulate, write back or hand to output ----
   assign base_p1     = fwd_p1_q ? fwd_data_p1_q : ram_rdata;
   assign acc_p1      = first_p1_q ? sum_p1_q : base_p1 + sum_p1_q;
   assign wr_en_p1    = vld_p1_q && !last_p1_q && !stall;
   assign load_out_p1 = vld_p1_q && last_p1_q && !stall;

`ifdef PSUM_ACC_RELU_EN
   assign final_p1 = clamp_neg(acc_p1);
`else
   assign final_p1 = acc_p1;
`endif

   // ---- Stage 2: output register ----
   // A new result may load in the same cycle the held one drains, since
   // stall is low whenever the register is empty or being taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q  <= 1'b0;
         out_addr_q <= '0;
         out_data_q <= '0;
      end else if (load_out_p1) begin
         out_vld_q  <= 1'b1;
         out_addr_q <= addr_p1_q;
         out_data_q <= final_p1;
      end else if (psum_acc2omap_rdy) begin
         out_vld_q  <= 1'b0;
      end
   end

   assign psum_acc2omap_vld  = out_vld_q;
   assign psum_acc2omap_addr = out_addr_q;
   assign psum_acc2omap_data = out_data_q;

endmodule

// File: tb/tb_psum_acc.sv
module tb_psum_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic        conv_start;
   logic [7:0]  in_ch;
   logic [15:0] map_size;
   logic [7:0]  acc_ch_cnt;
   logic        acc_done;
   logic [31:0] m_addr;
   logic [63:0] m_data;
   logic        m_vld;
   logic        m_rdy;
   logic [31:0] o_addr;
   logic [31:0] o_data;
   logic        o_vld;
   logic        o_rdy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_drain_cyc = 0;
   logic [31:0] got_data[$];
   logic [31:0] got_addr[$];

   psum_acc dut (
      .clk                     (clk),
      .rst                     (rst),
      .conv_start              (conv_start),
      .in_ch                   (in_ch),
      .map_size                (map_size),
      .acc_ch_cnt              (acc_ch_cnt),
      .acc_done                (acc_done),
      .mac_array2psum_acc_addr (m_addr),
      .mac_array2psum_acc_data (m_data),
      .mac_array2psum_acc_vld  (m_vld),
      .mac_array2psum_acc_rdy  (m_rdy),
      .psum_acc2omap_addr      (o_addr),
      .psum_acc2omap_data      (o_data),
      .psum_acc2omap_vld       (o_vld),
      .psum_acc2omap_rdy       (o_rdy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record output handshakes and done pulses half a cycle before the edge
   always @(negedge clk) begin
      if (!rst && o_vld && o_rdy) begin
         got_data.push_back(o_data);
         got_addr.push_back(o_addr);
         last_drain_cyc = cyc;
      end
      if (!rst && acc_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout cycles=%0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] mk(input logic [7:0] id, input logic [23:0] s1,
                                      input logic [31:0] s3);
      return {id, s1, s3};
   endfunction

   function automatic logic [31:0] qdata(input int i);
      if (i < got_data.size()) return got_data[i];
      return 32'hxxxxxxxx;
   endfunction

   function automatic logic [31:0] qaddr(input int i);
      if (i < got_addr.size()) return got_addr[i];
      return 32'hxxxxxxxx;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [7:0] ch, input logic [15:0] ms);
      conv_start = 1'b1;
      in_ch      = ch;
      map_size   = ms;
      @(posedge clk); #1;
      conv_start = 1'b0;
   endtask

   task automatic send(input logic [31:0] a, input logic [63:0] d);
      int n = 0;
      m_vld  = 1'b1;
      m_addr = a;
      m_data = d;
      @(negedge clk);
      while (!m_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!m_rdy) chk("send_rdy", {31'd0, m_rdy}, 32'd1);
      @(posedge clk); #1;
      m_vld = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int start_cnt = done_cnt;
      int n = 0;
      while (done_cnt == start_cnt && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk(tag, 32'(done_cnt - start_cnt), 32'd1);
   endtask

   initial begin
      logic [31:0] s3a[3];
      logic [31:0] s3b[3];
      int prev_done;

      rst = 1'b1; conv_start = 1'b0; in_ch = '0; map_size = '0;
      m_addr = '0; m_data = '0; m_vld = 1'b0; o_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy",   {31'd0, m_rdy},    32'd0);
      chk("rst_vld",   {31'd0, o_vld},    32'd0);
      chk("rst_data",  o_data,            32'd0);
      chk("rst_addr",  o_addr,            32'd0);
      chk("rst_done",  {31'd0, acc_done}, 32'd0);
      chk("rst_chcnt", {24'd0, acc_ch_cnt}, 32'd0);
      rst = 1'b0;

      // Single pass, mixed field signs: 100 - 5 + 3 = 98
      got_data.delete(); got_addr.delete();
      start(8'd1, 16'd4);
      chk("t1_rdy_run", {31'd0, m_rdy}, 32'd1);
      for (int i = 0; i < 4; i++) send(32'h100 + i, mk(8'd3, 24'hFFFFFB, 32'd100));
      wait_done("t1_done");
      chk("t1_count", 32'(got_data.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_data", qdata(i), 32'd98);
         chk("t1_addr", qaddr(i), 32'h100 + i);
      end
      chk("t1_done_lat", 32'(done_cyc - last_drain_cyc), 32'd1);

      // Three passes over two pixels: 1+10+100, 2+20+200
      got_data.delete(); got_addr.delete();
      s3a = '{32'd1, 32'd10, 32'd100};
      s3b = '{32'd2, 32'd20, 32'd200};
      start(8'd3, 16'd2);
      for (int p = 0; p < 3; p++) begin
         chk("t2_chcnt", {24'd0, acc_ch_cnt}, p);
         send(32'h200, mk(8'd0, 24'd0, s3a[p]));
         send(32'h201, mk(8'd0, 24'd0, s3b[p]));
      end
      wait_done("t2_done");
      chk("t2_count", 32'(got_data.size()), 32'd2);
      chk("t2_data0", qdata(0), 32'd111);
      chk("t2_addr0", qaddr(0), 32'h200);
      chk("t2_data1", qdata(1), 32'd222);
      chk("t2_addr1", qaddr(1), 32'h201);

      // One pixel, four back-to-back passes: needs forwarding, 4*10 = 40
      got_data.delete(); got_addr.delete();
      start(8'd4, 16'd1);
      for (int p = 0; p < 4; p++) send(32'h35, mk(8'd0, 24'd0, 32'd10));
      wait_done("t3_done");
      chk("t3_count", 32'(got_data.size()), 32'd1);
      chk("t3_data",  qdata(0), 32'd40);
      chk("t3_addr",  qaddr(0), 32'h35);

      // Backpressure: downstream not ready while results pile up
      got_data.delete(); got_addr.delete();
      o_rdy = 1'b0;
      start(8'd1, 16'd4);
      send(32'h40, mk(8'd0, 24'd0, 32'd5));
      send(32'h41, mk(8'd0, 24'd0, 32'd6));
      m_vld  = 1'b1;
      m_addr = 32'h42;
      m_data = mk(8'd0, 24'd0, 32'd7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_stall_rdy",  {31'd0, m_rdy}, 32'd0);
         chk("t4_stall_vld",  {31'd0, o_vld}, 32'd1);
         chk("t4_stall_data", o_data, 32'd5);
      end
      @(posedge clk); #1;
      o_rdy = 1'b1;
      send(32'h42, mk(8'd0, 24'd0, 32'd7));
      send(32'h43, mk(8'd0, 24'd0, 32'd8));
      wait_done("t4_done");
      chk("t4_count", 32'(got_data.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t4_data", qdata(i), 32'd5 + i);
         chk("t4_addr", qaddr(i), 32'h40 + i);
      end

      // Negative result: clamped with the ReLU build, raw otherwise
      got_data.delete(); got_addr.delete();
      start(8'd0, 16'd1);
      send(32'h50, mk(8'd0, 24'd0, 32'hFFFFFFCE));
      wait_done("t5_done");
      chk("t5_count", 32'(got_data.size()), 32'd1);
`ifdef PSUM_ACC_RELU_EN
      chk("t5_data", qdata(0), 32'd0);
`else
      chk("t5_data", qdata(0), 32'hFFFFFFCE);
`endif

      // Reset mid-pass, then a clean single-pass run over the same pixels
      got_data.delete(); got_addr.delete();
      start(8'd2, 16'd4);
      send(32'h60, mk(8'd0, 24'd0, 32'd999));
      send(32'h61, mk(8'd0, 24'd0, 32'd999));
      prev_done = done_cnt;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("t6_rst_rdy",   {31'd0, m_rdy}, 32'd0);
      chk("t6_rst_vld",   {31'd0, o_vld}, 32'd0);
      chk("t6_rst_chcnt", {24'd0, acc_ch_cnt}, 32'd0);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("t6_no_done", 32'(done_cnt - prev_done), 32'd0);
      chk("t6_no_out",  32'(got_data.size()), 32'd0);
      start(8'd1, 16'd4);
      for (int i = 0; i < 4; i++) send(32'h60 + i, mk(8'd0, 24'd0, 32'd7));
      wait_done("t6_done");
      chk("t6_count", 32'(got_data.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t6_data", qdata(i), 32'd7);
         chk("t6_addr", qaddr(i), 32'h60 + i);
      end

      // Empty map: straight to completion with no output
      got_data.delete(); got_addr.delete();
      start(8'd5, 16'd0);
      chk("t7_rdy", {31'd0, m_rdy}, 32'd0);
      wait_done("t7_done");
      chk("t7_count", 32'(got_data.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
